// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types for the inter-stage pipeline registers.
//   stage_state_e : occupancy state of a stage register (EMPTY / ONE / FULL).
//   id_ex_ctrl_t  : ID/EX control vector, 11 bits, carried as the ctrl field.
//   ID_EX_BUBBLE  : control value of a bubble (every write/read enable off).
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Encoding equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  typedef struct packed {
    logic [1:0] alu_src;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic       read_enable;
    logic [2:0] alu_op;
    logic       choose_rd;
  } id_ex_ctrl_t;

  localparam int unsigned ID_EX_CTRL_W = $bits(id_ex_ctrl_t);
  localparam id_ex_ctrl_t ID_EX_BUBBLE = '0;
  localparam int unsigned PIPE_DATA_W  = 148;

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One entry of a stage register: valid flag, control vector and payload.
//   clk, reset_n : clock, asynchronous active-low reset
//   load_i       : capture data_i/ctrl_i and mark the entry valid
//   clear_i      : drop the entry (valid=0); payload and control hold
//   data_i/ctrl_i: entry contents to load
//   valid_o      : entry holds a beat
//   data_o/ctrl_o: stored payload and control
// clear_i wins over load_i, so a squash can never be undone by a load.
// -----------------------------------------------------------------------------
module pipe_slot #(
  parameter int unsigned       DATA_W      = 148,
  parameter int unsigned       CTRL_W      = 11,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  // NOTE: these are plain flops, not a RAM, so resetting the payload is cheap
  // and gives a defined out_data after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= BUBBLE_CTRL;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      ctrl_q  <= ctrl_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule : pipe_slot

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Inter-stage pipeline register with valid/ready flow control, stall and flush.
// An empty or flushed slot always presents BUBBLE_CTRL, so it never writes the
// register file or memory.
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   flush      : synchronous squash of held and same-cycle incoming beats
//   in_valid   : upstream beat valid        in_ready  : this stage accepts
//   in_data    : upstream payload           in_ctrl   : upstream control
//   out_valid  : downstream beat valid      out_ready : downstream accepts
//   out_data   : payload of oldest entry    out_ctrl  : its control / bubble
//   occupancy  : entries held (0..2)
// SKID=1: main + skid entry, in_ready registered (no out_ready->in_ready path).
// SKID=0: main entry only, in_ready = !out_valid | out_ready.
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W      = PIPE_DATA_W,
  parameter int unsigned       CTRL_W      = ID_EX_CTRL_W,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter bit                SKID        = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  stage_state_e      state_q, state_d;
  logic              ready_q;
  logic              accept, issue;
  logic              main_load, main_clear, skid_load, skid_clear;
  logic [DATA_W-1:0] main_data_d;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  assign issue  = main_valid & out_ready;
  assign accept = in_valid & in_ready & ~flush;

  // With SKID=0 the FSM never reaches ST_FULL: in ST_ONE in_ready equals
  // out_ready, so every accept there coincides with an issue.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches.
    state_d     = state_q;
    main_load   = 1'b0;
    main_clear  = 1'b0;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    main_data_d = in_data;
    main_ctrl_d = in_ctrl;
    if (flush) begin
      state_d    = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && issue) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end else if (issue) begin
            main_clear = 1'b1;
            state_d    = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Skid beat is older than anything upstream: it moves to main.
          if (issue) begin
            main_load   = 1'b1;
            main_data_d = skid_data;
            main_ctrl_d = skid_ctrl;
            skid_clear  = 1'b1;
            state_d     = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // ready_q comes up one edge after reset release; with SKID=1 it is also the
  // registered "not full" flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= SKID ? (state_d != ST_FULL) : 1'b1;
    end
  end

  pipe_slot #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .BUBBLE_CTRL (BUBBLE_CTRL)
  ) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (main_load),
    .clear_i (main_clear),
    .data_i  (main_data_d),
    .ctrl_i  (main_ctrl_d),
    .valid_o (main_valid),
    .data_o  (main_data),
    .ctrl_o  (main_ctrl)
  );

  if (SKID) begin : g_skid
    pipe_slot #(
      .DATA_W      (DATA_W),
      .CTRL_W      (CTRL_W),
      .BUBBLE_CTRL (BUBBLE_CTRL)
    ) u_skid (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .data_i  (in_data),
      .ctrl_i  (in_ctrl),
      .valid_o (skid_valid),
      .data_o  (skid_data),
      .ctrl_o  (skid_ctrl)
    );
    assign in_ready = ready_q;
  end else begin : g_noskid
    assign skid_valid = 1'b0;
    assign skid_data  = '0;
    assign skid_ctrl  = BUBBLE_CTRL;
    assign in_ready   = ready_q & (~main_valid | out_ready);
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : BUBBLE_CTRL;
  // Counted from the entry flags so it drops to 0 the instant reset asserts.
  assign occupancy = 2'(main_valid) + 2'(skid_valid);

endmodule : pipe_stage_reg
